display_scan: RTL and testbench
===============================

// Module: display_scan
// PURPOSE
//  Multiplexed scan driver for an N-digit seven-segment display.
//  Sits directly upstream of the 7-segment decoder (inputs i1..i4, outputs a..g).
//  - Latches N BCD/hex nibbles; presents one nibble per time slot on nibble[3:0].
//  - Drives active-low digit enables (an_n) in step with the nibble.
//  - Blanks all digits at each slot boundary to suppress ghosting.
// PARAMETERS
//  N_DIGITS      4      number of digits scanned (>=2)
//  PRESCALE      50000  clk cycles per digit slot (>=2)
//  BLANK_CYCLES  2      cycles at start of each slot with all digits off (1..PRESCALE-1)
// PORTS
//  clk         in   1            system clock, rising edge
//  rst         in   1            asynchronous, active-high reset
//  load        in   1            1-cycle strobe: capture data/blank_mask into shadow buffer
//  data        in   4*N_DIGITS   nibble k = data[4k+3:4k]; digit 0 = rightmost
//  blank_mask  in   N_DIGITS     1 = digit k never enabled (leading-zero blanking)
//  nibble      out  4            current digit value to decoder; nibble[3]=i1 (MSB) .. nibble[0]=i4
//  an_n        out  N_DIGITS     active-low digit enables; at most one bit low
//  frame_done  out  1            1-cycle pulse on the last cycle of digit N_DIGITS-1's slot
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - Outputs: nibble=0, an_n=all 1, frame_done=0.
//   - Internal: shadow/active buffers=0, pending=0, idx=0, slot_cnt=0, state=BLANK.
//  Slot timing:
//   - slot_cnt counts 0..PRESCALE-1, then wraps to 0 and idx advances.
//   - idx counts 0..N_DIGITS-1, then wraps to 0.
//  FSM, two states:
//   - BLANK: slot_cnt in [0, BLANK_CYCLES-1]; an_n = all 1.
//   - SHOW: slot_cnt in [BLANK_CYCLES, PRESCALE-1];
//     an_n[idx]=0 unless active_mask[idx]=1; all other an_n bits =1.
//   - BLANK->SHOW when slot_cnt==BLANK_CYCLES-1.
//   - SHOW->BLANK when slot_cnt==PRESCALE-1.
//  Registered outputs:
//   - nibble updates to active_data[idx] on the first BLANK cycle of each slot.
//   - So nibble is stable >= BLANK_CYCLES cycles before its enable goes low.
//   - Decoder settles while display is dark.
//  Load / tear-free update:
//   - load=1 copies data, blank_mask into shadow and sets pending.
//   - Repeated loads overwrite shadow; last one wins.
//  Frame boundary (slot_cnt==PRESCALE-1 and idx==N_DIGITS-1):
//   - frame_done=1 for that cycle.
//   - If pending: active<=shadow, pending<=0.
//   - New frame (idx=0) uses new data.
//  Simultaneous load and frame boundary:
//   - Incoming data goes to shadow; the shadow contents before that edge go to active.
//   - pending stays 1; new data appears the frame after.
//  Other rules:
//   - Mid-frame load never alters the active frame.
//   - Reset mid-slot: all outputs return to reset values immediately (async).
//   - Scan restarts at idx=0, BLANK, on first clk after release.
//   - Latency from load to visible digit 0: up to N_DIGITS*PRESCALE + BLANK_CYCLES cycles.
// TESTING  (N_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2)
//  1. Reset release, no load -> an_n=1111 cycles 0-1.
//     Then an_n=1110 cycles 2-7, nibble=0.
//     Then blank 2 cycles, an_n=1101, etc.
//     frame_done at cycle 31.
//  2. load data=16'h4321 before frame 0 boundary.
//     -> next frame: nibble 1,2,3,4 on slots 0-3.
//     -> each nibble present 2 cycles before its an_n bit drops.
//  3. load mid-frame (cycle 12) with 16'h9876.
//     -> remainder of frame unchanged.
//     -> 6,7,8,9 shown from the frame starting cycle 32.
//  4. load coincident with frame_done cycle.
//     -> previous shadow applied now; new data one frame later.
//  5. blank_mask=4'b1100 with data=16'h0042.
//     -> an_n never 0111 or 1011; slots 2-3 stay all-1.
//     -> nibble still cycles 2,4,0,0.
//  6. Assert rst during SHOW of slot 2 (async) -> an_n=1111, nibble=0 same cycle.
//     -> after release, scan restarts at slot 0; active buffer = 0.
//  Checker on every cycle: an_n has at most one 0 bit.

Source files
------------

// File: rtl/display_scan.sv
// Multiplexed scan driver for an N-digit seven-segment display: one nibble per
// time slot, active-low digit enables, and a dark gap at every slot boundary.
module display_scan #(
  parameter int N_DIGITS     = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] data,
  input  logic [N_DIGITS-1:0]   blank_mask,
  output logic [3:0]            nibble,
  output logic [N_DIGITS-1:0]   an_n,
  output logic                  frame_done,
  output logic                  state_dbg
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

  typedef enum logic {ST_BLANK = 1'b0, ST_SHOW = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         slot_cnt_q, slot_cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*N_DIGITS-1:0] shadow_data_q, shadow_data_d;
  logic [N_DIGITS-1:0]   shadow_mask_q, shadow_mask_d;
  logic [4*N_DIGITS-1:0] active_data_q, active_data_d;
  logic [N_DIGITS-1:0]   active_mask_q, active_mask_d;
  logic                  pending_q, pending_d;
  logic [3:0]            nibble_q, nibble_d;
  logic                  slot_end, frame_end;

  assign slot_end  = (slot_cnt_q == CNT_LAST);
  assign frame_end = slot_end && (idx_q == IDX_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_BLANK;
      slot_cnt_q    <= '0;
      idx_q         <= '0;
      shadow_data_q <= '0;
      shadow_mask_q <= '0;
      active_data_q <= '0;
      active_mask_q <= '0;
      pending_q     <= 1'b0;
      nibble_q      <= '0;
    end else begin
      state_q       <= state_d;
      slot_cnt_q    <= slot_cnt_d;
      idx_q         <= idx_d;
      shadow_data_q <= shadow_data_d;
      shadow_mask_q <= shadow_mask_d;
      active_data_q <= active_data_d;
      active_mask_q <= active_mask_d;
      pending_q     <= pending_d;
      nibble_q      <= nibble_d;
    end
  end

  // Datapath: slot timing, double-buffered frame data, nibble pre-load.
  always_comb begin
    slot_cnt_d    = slot_end ? '0 : slot_cnt_q + CW'(1);
    idx_d         = idx_q;
    if (slot_end) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);

    shadow_data_d = load ? data : shadow_data_q;
    shadow_mask_d = load ? blank_mask : shadow_mask_q;

    // Active takes the pre-edge shadow, so a coincident load waits a frame.
    active_data_d = active_data_q;
    active_mask_d = active_mask_q;
    if (frame_end && pending_q) begin
      active_data_d = shadow_data_q;
      active_mask_d = shadow_mask_q;
    end
    pending_d = load ? 1'b1 : (frame_end ? 1'b0 : pending_q);

    // Next slot's digit is registered as the slot opens, while still dark.
    nibble_d = nibble_q;
    if (slot_end) begin
      nibble_d = '0;
      for (int k = 0; k < N_DIGITS; k++)
        if (idx_d == IW'(k)) nibble_d = active_data_d[4*k +: 4];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BLANK: if (slot_cnt_q == BLANK_LAST) state_d = ST_SHOW;
      ST_SHOW:  if (slot_end)                 state_d = ST_BLANK;
      default:                                state_d = ST_BLANK;
    endcase
  end

  always_comb begin
    an_n = '1;
    if (state_q == ST_SHOW) begin
      for (int k = 0; k < N_DIGITS; k++)
        if ((idx_q == IW'(k)) && !active_mask_q[k]) an_n[k] = 1'b0;
    end
  end

  assign frame_done = frame_end;
  assign nibble     = nibble_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan (N_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2):
// per-frame expected nibbles are queued as stimulus is planned, then checked every cycle.
module tb_display_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] data;
  logic [3:0]  blank_mask;
  logic [3:0]  nibble;
  logic [3:0]  an_n;
  logic        frame_done;
  logic        state_dbg;

  display_scan #(.N_DIGITS(4), .PRESCALE(8), .BLANK_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .load(load), .data(data), .blank_mask(blank_mask),
    .nibble(nibble), .an_n(an_n), .frame_done(frame_done), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          frame;
    int          cyc;
    logic [15:0] d;
    logic [3:0]  m;
  } ld_t;

  ld_t        ld_tab[$];
  logic [3:0] exp_q[$];
  logic [3:0] cur_nib;
  int         frame_no = 0;
  int         n_tests  = 0;
  int         n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s frame=%0d observed=%h expected=%h", tag, frame_no, obs, exp);
    end
  endtask

  // Runs one 32-cycle frame; optionally asserts rst mid-cycle at cycle rst_at.
  task automatic run_frame(input logic [15:0] ed, input logic [3:0] em, input int rst_at);
    for (int k = 0; k < 4; k++) exp_q.push_back(ed[4*k +: 4]);
    for (int c = 0; c < 32; c++) begin
      int         slot;
      int         idx;
      logic [3:0] ea;
      slot = c % 8;
      idx  = c / 8;
      if (slot == 0) cur_nib = exp_q.pop_front();
      ea = 4'hF;
      if (slot >= 2 && !em[idx]) ea[idx] = 1'b0;
      chk("an_n", 32'(an_n), 32'(ea));
      chk("frame_done", 32'(frame_done), 32'(c == 31));
      chk("nibble", 32'(nibble), 32'(cur_nib));
      chk("state", 32'(state_dbg), 32'(slot >= 2));
      chk("an_n_onehot", 32'($countones(~an_n) <= 1), 32'(1));
      if (c == rst_at) begin
        #2;
        rst  = 1'b1;
        load = 1'b0;
        #1;
        chk("rst_an_n", 32'(an_n), 32'hF);
        chk("rst_nibble", 32'(nibble), 32'h0);
        chk("rst_frame_done", 32'(frame_done), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        exp_q.delete();
        frame_no++;
        return;
      end
      load = 1'b0;
      if (ld_tab.size() > 0 && ld_tab[0].frame == frame_no && ld_tab[0].cyc == c) begin
        load       = 1'b1;
        data       = ld_tab[0].d;
        blank_mask = ld_tab[0].m;
        void'(ld_tab.pop_front());
      end
      @(posedge clk);
      #1;
    end
    frame_no++;
  endtask

  initial begin
    rst        = 1'b1;
    load       = 1'b0;
    data       = '0;
    blank_mask = '0;
    cur_nib    = '0;

    ld_tab.push_back('{0, 20, 16'h4321, 4'b0000});
    ld_tab.push_back('{1, 12, 16'h9876, 4'b0000});
    ld_tab.push_back('{2,  5, 16'h1111, 4'b0000});
    ld_tab.push_back('{2, 10, 16'hCDEF, 4'b0000});
    ld_tab.push_back('{2, 31, 16'h5A5A, 4'b0000});
    ld_tab.push_back('{4,  3, 16'h0042, 4'b1100});
    ld_tab.push_back('{5,  4, 16'hFEDC, 4'b0000});
    ld_tab.push_back('{6,  5, 16'hFFFF, 4'b0000});

    repeat (3) @(posedge clk);
    #1;
    chk("reset_an_n", 32'(an_n), 32'hF);
    chk("reset_nibble", 32'(nibble), 32'h0);
    chk("reset_frame_done", 32'(frame_done), 32'h0);
    rst = 1'b0;
    #1;

    run_frame(16'h0000, 4'b0000, -1);
    run_frame(16'h4321, 4'b0000, -1);
    run_frame(16'h9876, 4'b0000, -1);
    run_frame(16'hCDEF, 4'b0000, -1);
    run_frame(16'h5A5A, 4'b0000, -1);
    run_frame(16'h0042, 4'b1100, -1);
    run_frame(16'hFEDC, 4'b0000, 19);
    run_frame(16'h0000, 4'b0000, -1);
    run_frame(16'h0000, 4'b0000, -1);

    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
